// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by fetch_unit and its testbench.
package fetch_pkg;
  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IW    = $clog2(LUT_DEPTH);

  localparam logic [PC_W-1:0]    START_PC   = '0;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Jump-target register file: async read, sync write,
// async reset of every entry to zero.
module jump_lut #(
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [IW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, jump LUT, ROM drive, start/done.
// FETCH_PERF_CNT_EN enables the retired-instruction counter.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               pc_jmp_en,
  input  logic [LUT_IW-1:0]  lut_ptr,
  input  logic               lut_wr_en,
  input  logic [LUT_IW-1:0]  lut_wr_addr,
  input  logic [PC_W-1:0]    lut_wr_data,
  output logic [PC_W-1:0]    instr_mem_addr,
  input  logic [INSTR_W-1:0] instr_mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    cur_pc,
  output logic               busy,
  output logic               done,
  output logic [15:0]        instr_count
);
  fetch_state_t    r_state;
  fetch_state_t    w_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_run_addr;
  logic            w_run;
  logic            w_idle;
  logic            w_go;
  logic            w_halt;
  logic            w_eom;

  assign w_run  = r_state == RUN;
  assign w_idle = (r_state == IDLE) || (r_state == DONE);
  assign w_go   = w_idle && start;
  assign w_halt = w_run && (instr_mem_rdata == HALT_INSTR);
  assign w_eom  = r_pc == '1;

  jump_lut #(
    .DEPTH (LUT_DEPTH),
    .IW    (LUT_IW),
    .DW    (PC_W)
  ) u_lut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_idle && lut_wr_en),
    .i_wr_addr (lut_wr_addr),
    .i_wr_data (lut_wr_data),
    .i_rd_addr (lut_ptr),
    .o_rd_data (w_tgt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_go) w_next = PRIME;
      PRIME:      w_next = RUN;
      RUN: begin
        if (!stall && (w_halt || (w_eom && !pc_jmp_en)))
          w_next = DONE;
      end
      default:    w_next = IDLE;
    endcase
  end

  // Halt and end-of-memory both park the PC; it never wraps.
  always_comb begin
    if (stall || w_halt)  w_run_addr = r_pc;
    else if (pc_jmp_en)   w_run_addr = w_tgt;
    else if (w_eom)       w_run_addr = r_pc;
    else                  w_run_addr = r_pc + PC_W'(1);
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    instr_valid    = 1'b0;
    instr_mem_addr = r_pc;
    unique case (1'b1)
      r_state == PRIME: begin
        busy           = 1'b1;
        instr_mem_addr = START_PC;
      end
      w_run: begin
        busy           = 1'b1;
        instr_valid    = 1'b1;
        instr_mem_addr = w_run_addr;
      end
      r_state == DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= START_PC;
    else if (r_state == PRIME || w_run)
      r_pc <= instr_mem_addr;
  end

  assign instr  = instr_valid ? instr_mem_rdata : '0;
  assign cur_pc = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_go)
      r_cnt <= '0;
    else if (w_run && !stall && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end

  assign instr_count = r_cnt;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios
// plus random traffic against a behavioural fetch model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;
  localparam int LAST_PC = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        pc_jmp_en = 1'b0;
  logic [3:0]  lut_ptr = '0;
  logic        lut_wr_en = 1'b0;
  logic [3:0]  lut_wr_addr = '0;
  logic [9:0]  lut_wr_data = '0;
  logic [9:0]  instr_mem_addr;
  logic [8:0]  instr_mem_rdata;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [9:0]  cur_pc;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;

  logic [8:0]  rom [1024];

  int n_cmp = 0;
  int n_err = 0;

  int m_ph;
  int m_pc;
  int m_cnt;
  int m_lut [16];

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stall           (stall),
    .pc_jmp_en       (pc_jmp_en),
    .lut_ptr         (lut_ptr),
    .lut_wr_en       (lut_wr_en),
    .lut_wr_addr     (lut_wr_addr),
    .lut_wr_data     (lut_wr_data),
    .instr_mem_addr  (instr_mem_addr),
    .instr_mem_rdata (instr_mem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .cur_pc          (cur_pc),
    .busy            (busy),
    .done            (done),
    .instr_count     (instr_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) instr_mem_rdata <= rom[instr_mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph  = M_IDLE;
    m_pc  = 0;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  function automatic bit is_halt(input int pc);
    return rom[pc] == 9'h1FF;
  endfunction

  function automatic int exp_addr();
    if (m_ph == M_PRIME) return 0;
    if (m_ph != M_RUN)   return m_pc;
    if (stall)           return m_pc;
    if (is_halt(m_pc))   return m_pc;
    if (pc_jmp_en)       return m_lut[lut_ptr];
    if (m_pc == LAST_PC) return m_pc;
    return m_pc + 1;
  endfunction

  task automatic check_outputs();
    int run;
    int e_cnt;
    run = (m_ph == M_RUN) ? 1 : 0;
`ifdef FETCH_PERF_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 0;
`endif
    chk("busy", 32'(busy),
        32'((m_ph == M_PRIME || m_ph == M_RUN) ? 1 : 0));
    chk("done", 32'(done), 32'((m_ph == M_DONE) ? 1 : 0));
    chk("valid", 32'(instr_valid), 32'(run));
    chk("cur_pc", 32'(cur_pc), 32'(m_pc));
    chk("instr", 32'(instr), run != 0 ? 32'(rom[m_pc]) : 32'd0);
    chk("addr", 32'(instr_mem_addr), 32'(exp_addr()));
    chk("count", 32'(instr_count), 32'(e_cnt));
  endtask

  task automatic model_step();
    case (m_ph)
      M_PRIME: begin
        m_pc = 0;
        m_ph = M_RUN;
      end
      M_RUN: begin
        if (!stall) begin
          if (m_cnt < 65535) m_cnt++;
          if (is_halt(m_pc))         m_ph = M_DONE;
          else if (pc_jmp_en)        m_pc = m_lut[lut_ptr];
          else if (m_pc == LAST_PC)  m_ph = M_DONE;
          else                       m_pc++;
        end
      end
      default: begin
        if (lut_wr_en) m_lut[lut_wr_addr] = 32'(lut_wr_data);
        if (start) begin
          m_ph  = M_PRIME;
          m_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    #1;
    check_outputs();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    start = 0; stall = 0; pc_jmp_en = 0; lut_ptr = '0;
    lut_wr_en = 0; lut_wr_addr = '0; lut_wr_data = '0;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++)
      rom[i] = 9'($urandom_range(0, 510));
  endtask

  task automatic lut_write(input int a, input int d);
    lut_wr_en = 1; lut_wr_addr = 4'(a); lut_wr_data = 10'(d);
    step();
    clr();
  endtask

  task automatic begin_run();
    start = 1;
    step();
    start = 0;
    step();
  endtask

  task automatic run_to_done(input int max);
    int k = 0;
    while (m_ph != M_DONE && k < max) begin
      step();
      k++;
    end
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    fill_rom();
    model_reset();
    step();
    rst_n = 1;
    step();

    // straight line, halt at 4
    rom[4] = 9'h1FF;
    begin_run();
    repeat (5) step();
    step();
    chk("sl_done", 32'(done), 32'd1);
    chk("sl_pc", 32'(cur_pc), 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("sl_cnt", 32'(instr_count), 32'd5);
`else
    chk("sl_cnt", 32'(instr_count), 32'd0);
`endif

    // zero-bubble jump at pc 2
    fill_rom();
    rom[45] = 9'h1FF;
    lut_write(3, 40);
    begin_run();
    repeat (2) step();
    pc_jmp_en = 1; lut_ptr = 4'd3;
    step();
    clr();
    chk("jmp_pc", 32'(cur_pc), 32'd40);
    chk("jmp_instr", 32'(instr), 32'(rom[40]));
    run_to_done(20);

    // stall beats jump; busy LUT write ignored
    begin_run();
    repeat (5) step();
    stall = 1; pc_jmp_en = 1; lut_ptr = 4'd3;
    lut_wr_en = 1; lut_wr_addr = 4'd3; lut_wr_data = 10'd100;
    repeat (3) step();
    chk("stall_pc", 32'(cur_pc), 32'd5);
    chk("stall_instr", 32'(instr), 32'(rom[5]));
    stall = 0; lut_wr_en = 0;
    step();
    clr();
    chk("stall_jmp", 32'(cur_pc), 32'd40);
    run_to_done(20);

    // same write in DONE lands
    rom[102] = 9'h1FF;
    lut_write(3, 100);
    begin_run();
    pc_jmp_en = 1; lut_ptr = 4'd3;
    step();
    clr();
    chk("done_wr", 32'(cur_pc), 32'd100);
    run_to_done(10);

    // end of memory
    fill_rom();
    lut_write(5, 1020);
    begin_run();
    pc_jmp_en = 1; lut_ptr = 4'd5;
    step();
    clr();
    run_to_done(20);
    chk("eom_pc", 32'(cur_pc), 32'd1023);
    repeat (3) step();

    // reset mid-run at pc 7
    fill_rom();
    lut_write(2, 300);
    begin_run();
    repeat (7) step();
    chk("pre_rst_pc", 32'(cur_pc), 32'd7);
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(cur_pc), 32'd0);
    step();
    step();
    rst_n = 1;
    step();
    rom[1] = 9'h1FF;
    for (int p = 0; p < 16; p++) begin
      begin_run();
      pc_jmp_en = 1; lut_ptr = 4'(p);
      step();
      clr();
      chk("lut_zero", 32'(cur_pc), 32'd0);
      run_to_done(10);
    end

    // random traffic
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? 9'h1FF
             : 9'($urandom_range(0, 510));
    for (int i = 0; i < 16; i++)
      lut_write(i, int'($urandom_range(0, 1023)));
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      pc_jmp_en   = ($urandom_range(0, 3) == 0);
      lut_ptr     = 4'($urandom_range(0, 15));
      lut_wr_en   = ($urandom_range(0, 4) == 0);
      lut_wr_addr = 4'($urandom_range(0, 15));
      lut_wr_data = 10'($urandom_range(0, 1023));
      step();
    end
    clr();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
